dmem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port, synchronous-read data memory between the core load/store unit (port 0) and the program/data loader (port 1). Each cycle it grants at most one request, drives the memory port, tags the read in flight, and routes the read data back one cycle later with a valid strobe to the owner. It sits between the LSU/loader and the data memory macro.

---
 rtl/dmem_pkg.sv | 11 +
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arb_core.sv | 61 ++++++
 rtl/dmem_arbiter.sv | 82 ++++++++
 tb/tb_dmem_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared data-memory types for the arbiter, LSU and loader
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        PORT_CORE   = 1'b0,
        PORT_LOADER = 1'b1
    } port_id_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory-side signals of the dmem arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);

    logic                        req0;
    logic                        req1;
    logic                        we0;
    logic                        we1;
    logic [ADDR_W-1:0]           addr0;
    logic [ADDR_W-1:0]           addr1;
    logic [dmem_pkg::WORD_W-1:0] wd0;
    logic [dmem_pkg::WORD_W-1:0] wd1;
    logic                        gnt0;
    logic                        gnt1;
    logic                        rvalid0;
    logic                        rvalid1;
    logic [dmem_pkg::WORD_W-1:0] rdata;
    logic                        misalign;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [dmem_pkg::WORD_W-1:0] mem_wd;
    logic [dmem_pkg::WORD_W-1:0] mem_rd;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wd0, wd1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, misalign,
        output mem_we, mem_addr, mem_wd,
        input  mem_rd
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wd0, wd1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, misalign,
        input  mem_we, mem_addr, mem_wd,
        output mem_rd
    );

endinterface

// File: rtl/dmem_arb_core.sv
// rtl/dmem_arb_core.sv - grant decision; DMEM_ARB_RR_EN selects round-robin, else fixed priority with starvation guard
module dmem_arb_core
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef DMEM_ARB_RR_EN

    port_id_t last_q;

    // Reset to the loader so the core wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_LOADER;
        end else if (gnt0) begin
            last_q <= PORT_CORE;
        end else if (gnt1) begin
            last_q <= PORT_LOADER;
        end
    end

    always_comb begin
        gnt0 = req0 && (!req1 || (last_q == PORT_LOADER));
        gnt1 = req1 && !gnt0;
    end

`else

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_q;
    logic             starved;

    assign starved = (wait_q == CNT_W'(MAX_WAIT));

    always_comb begin
        gnt1 = req1 && (!req0 || starved);
        gnt0 = req0 && !gnt1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (!req1 || gnt1) begin
            wait_q <= '0;
        end else if (!starved) begin
            wait_q <= wait_q + 1'b1;
        end
    end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter: grant, memory mux, read-tag pipeline, misalign flag
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);

    logic                gnt0;
    logic                gnt1;
    logic                granted;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wd;
    logic                rd_pend;
    port_id_t            rd_owner;
    logic [WORD_W-1:0]   rdata_q;
    logic                misalign_q;

    dmem_arb_core #(
        .MAX_WAIT (MAX_WAIT)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .req0 (bus.req0),
        .req1 (bus.req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign granted = gnt0 | gnt1;

    // Idle cycles park the memory port on the core's inputs with writes off.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = bus.addr0;
        mem_wd   = bus.wd0;
        if (gnt1) begin
            mem_we   = bus.we1;
            mem_addr = bus.addr1;
            mem_wd   = bus.wd1;
        end else if (gnt0) begin
            mem_we   = bus.we0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            rd_owner   <= PORT_CORE;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            rd_pend <= granted && !mem_we;
            if (granted && !mem_we) begin
                rd_owner <= gnt1 ? PORT_LOADER : PORT_CORE;
            end
            if (rd_pend) begin
                rdata_q <= bus.mem_rd;
            end
            if (granted && (mem_addr[1:0] != 2'b00)) begin
                misalign_q <= 1'b1;
            end
        end
    end

    // mem_rd is valid in the cycle after the grant, which is when rvalid is up.
    assign bus.rdata    = rd_pend ? bus.mem_rd : rdata_q;
    assign bus.rvalid0  = rd_pend && (rd_owner == PORT_CORE);
    assign bus.rvalid1  = rd_pend && (rd_owner == PORT_LOADER);
    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.misalign = misalign_q;
    assign bus.mem_we   = mem_we;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_wd   = mem_wd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a write-first memory model
module tb_dmem_arbiter;

    logic clk;
    logic rst;

    int n_vec;
    int n_err;

    logic [31:0] mem [logic [29:0]];

    dmem_arbiter_if #(.ADDR_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W   (32),
        .MAX_WAIT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [29:0] w);
        if (mem.exists(w)) return mem[w];
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[31:2]] = bus.mem_wd;
            bus.mem_rd <= bus.mem_wd;
        end else begin
            bus.mem_rd <= mem_read(bus.mem_addr[31:2]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp1;
        int   p;
        int   prev_p;

        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wd0 = '0; bus.wd1 = '0;

        mem[30'h040] = 32'hDEADBEEF;
        mem[30'h080] = 32'h2222_0200;
        mem[30'h0C0] = 32'h3333_0300;
        for (int i = 0; i < 6; i++) mem[30'h100 + 30'(i)] = 32'hA000_0000 + 32'(i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rvalid0", bus.rvalid0, 0);
        check("rst_rvalid1", bus.rvalid1, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_misalign", bus.misalign, 0);
        check("rst_mem_we", bus.mem_we, 0);

        // single core read
        next_cycle();
        rst = 1'b0;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h100;
        @(negedge clk);
        check("rd_gnt0", bus.gnt0, 1);
        check("rd_gnt1", bus.gnt1, 0);
        check("rd_mem_addr", bus.mem_addr, 32'h100);
        next_cycle();
        bus.req0 = 0;
        @(negedge clk);
        check("rd_rvalid0", bus.rvalid0, 1);
        check("rd_rdata", bus.rdata, 32'hDEADBEEF);
        check("rd_rvalid1", bus.rvalid1, 0);
        next_cycle();
        @(negedge clk);
        check("idle_rvalid0", bus.rvalid0, 0);
        check("idle_rdata_hold", bus.rdata, 32'hDEADBEEF);

        // loader write then core read of same word
        next_cycle();
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'h104; bus.wd1 = 32'h12345678;
        @(negedge clk);
        check("wr_gnt1", bus.gnt1, 1);
        check("wr_mem_we", bus.mem_we, 1);
        check("wr_mem_wd", bus.mem_wd, 32'h12345678);
        next_cycle();
        bus.req1 = 0; bus.we1 = 0;
        bus.req0 = 1; bus.addr0 = 32'h104;
        @(negedge clk);
        check("raw_gnt0", bus.gnt0, 1);
        check("wr_no_rvalid1", bus.rvalid1, 0);
        check("raw_mem_we", bus.mem_we, 0);
        next_cycle();
        bus.req0 = 0;
        @(negedge clk);
        check("raw_rvalid0", bus.rvalid0, 1);
        check("raw_rdata", bus.rdata, 32'h12345678);

        // lone loader read leaves last grant with the loader
        next_cycle();
        bus.req1 = 1; bus.addr1 = 32'h300;
        @(negedge clk);
        check("lone_gnt1", bus.gnt1, 1);

        // continuous contention
        next_cycle();
        bus.req0 = 1; bus.addr0 = 32'h200;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("lone_rvalid1", bus.rvalid1, 1);
                check("lone_rdata", bus.rdata, 32'h3333_0300);
            end
`ifdef DMEM_ARB_RR_EN
            exp1 = (i % 2 == 0);
`else
            exp1 = (i % 9 == 0);
`endif
            check($sformatf("cont_gnt1_%0d", i), bus.gnt1, exp1);
            check($sformatf("cont_gnt0_%0d", i), bus.gnt0, !exp1);
            next_cycle();
        end
        bus.req0 = 0; bus.req1 = 0;

        // alternating reads, one per cycle
        prev_p = 0;
        for (int i = 0; i < 6; i++) begin
            p = i % 2;
            bus.req0 = (p == 0); bus.addr0 = 32'h400 + 32'(4 * i);
            bus.req1 = (p == 1); bus.addr1 = 32'h400 + 32'(4 * i);
            @(negedge clk);
            check($sformatf("alt_gnt_%0d", i), (p == 0) ? bus.gnt0 : bus.gnt1, 1);
            if (i > 0) begin
                check($sformatf("alt_rv_prev_%0d", i), (prev_p == 0) ? bus.rvalid0 : bus.rvalid1, 1);
                check($sformatf("alt_rv_cur_%0d", i), (p == 0) ? bus.rvalid0 : bus.rvalid1, 0);
                check($sformatf("alt_rdata_%0d", i), bus.rdata, 32'hA000_0000 + 32'(i - 1));
            end
            prev_p = p;
            next_cycle();
        end
        bus.req0 = 0; bus.req1 = 0;
        @(negedge clk);
        check("alt_last_rvalid1", bus.rvalid1, 1);
        check("alt_last_rdata", bus.rdata, 32'hA000_0005);

        // misaligned read
        next_cycle();
        bus.req0 = 1; bus.addr0 = 32'h102;
        @(negedge clk);
        check("mis_gnt0", bus.gnt0, 1);
        check("mis_mem_addr", bus.mem_addr, 32'h102);
        check("mis_not_yet", bus.misalign, 0);
        next_cycle();
        bus.req0 = 0;
        @(negedge clk);
        check("mis_set", bus.misalign, 1);
        check("mis_rdata", bus.rdata, 32'hDEADBEEF);
        next_cycle();
        @(negedge clk);
        check("mis_sticky", bus.misalign, 1);

        // reset while a read is pending
        next_cycle();
        bus.req0 = 1; bus.addr0 = 32'h200;
        @(negedge clk);
        check("rr_gnt0", bus.gnt0, 1);
        next_cycle();
        bus.req0 = 0;
        rst = 1'b1;
        @(negedge clk);
        check("rr_rvalid0_in_rst", bus.rvalid0, 0);
        check("rr_misalign_clr", bus.misalign, 0);
        check("rr_rdata_clr", bus.rdata, 0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rr_rvalid0_%0d", i), bus.rvalid0, 0);
            check($sformatf("rr_rvalid1_%0d", i), bus.rvalid1, 0);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
